adc_5g_sync_align: RTL and testbench

- Sits downstream of the 5G ADC interface, in the ctrl clock domain.
- Consumes the 8-sample/clock interleaved word plus the four phase-sync bits and two over-range bits.
- Re-aligns the sample stream so a sync edge always starts at sample 0 of an output word, flags the aligned sync, and counts sync/over-range events for software.

---
 rtl/adc_5g_pkg.sv | 45 ++++
 rtl/adc_5g_sat_counter.sv | 44 ++++
 rtl/adc_5g_sync_align.sv | 167 ++++++++++++++++
 tb/tb_adc_5g_sync_align.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/adc_5g_pkg.sv
// Shared sample geometry, aligner state encoding and the phase/alignment helpers
// for the 5G ADC sync aligner.
package adc_5g_pkg;

    localparam int SAMPLE_W       = 8;
    localparam int NSAMP          = 8;
    localparam int WORD_W         = SAMPLE_W * NSAMP;
    localparam int NPHASE         = 4;
    localparam int PHASE_W        = 2;
    localparam int SAMP_PER_PHASE = 2;
    localparam int PHASE_BITS     = SAMPLE_W * SAMP_PER_PHASE;

    typedef enum logic [0:0] {
        SEARCH = 1'b0,
        LOCKED = 1'b1
    } state_e;

    // Lowest set sync bit wins: bit 0 marks the earliest sample pair in time.
    function automatic logic [PHASE_W-1:0] sync_phase(input logic [NPHASE-1:0] sync);
        logic [PHASE_W-1:0] k;
        casez (sync)
            4'b???1: k = 2'd0;
            4'b??10: k = 2'd1;
            4'b?100: k = 2'd2;
            4'b1000: k = 2'd3;
            default: k = 2'd0;
        endcase
        return k;
    endfunction

    function automatic logic [WORD_W-1:0] align_word(input logic [WORD_W-1:0]  held,
                                                     input logic [WORD_W-1:0]  cur,
                                                     input logic [PHASE_W-1:0] k);
        logic [WORD_W-1:0] w;
        case (k)
            2'd0:    w = held;
            2'd1:    w = {cur[1*PHASE_BITS-1:0], held[WORD_W-1:1*PHASE_BITS]};
            2'd2:    w = {cur[2*PHASE_BITS-1:0], held[WORD_W-1:2*PHASE_BITS]};
            2'd3:    w = {cur[3*PHASE_BITS-1:0], held[WORD_W-1:3*PHASE_BITS]};
            default: w = held;
        endcase
        return w;
    endfunction

endpackage

// File: rtl/adc_5g_sat_counter.sv
// Event counter with synchronous clear (clear beats increment) and optional
// saturation at all-ones.
module adc_5g_sat_counter
    import adc_5g_pkg::*;
#(
    parameter int CNT_W    = 32,
    parameter bit SATURATE = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             inc,
    output logic [CNT_W-1:0] count
);

    localparam logic [CNT_W-1:0] ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    // Next count: clear, saturating increment or hold.
    always_comb begin
        count_d = count_q;
        if (clr) begin
            count_d = '0;
        end else if (inc && !(SATURATE && (&count_q))) begin
            count_d = count_q + ONE;
        end else begin
            count_d = count_q;
        end
    end

    // Count register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/adc_5g_sync_align.sv
// Re-aligns the 8-sample ADC word so a sync edge lands on sample 0, flags it and
// counts sync events. Define ADC5G_OVERRANGE_CNT_EN to build the over-range counter.
module adc_5g_sync_align
    import adc_5g_pkg::*;
#(
    parameter int CNT_W  = 32,
    parameter bit RELOCK = 1'b1
) (
    input  logic               ctrl_clk_in,
    input  logic               ctrl_reset_n,
    input  logic [WORD_W-1:0]  in_data,
    input  logic [NPHASE-1:0]  in_sync,
    input  logic [1:0]         in_or,
    input  logic               in_valid,
    input  logic               arm,
    input  logic               cnt_clr,
    output logic [WORD_W-1:0]  out_data,
    output logic               out_sync,
    output logic               out_valid,
    output logic               locked,
    output logic [PHASE_W-1:0] offset,
    output logic [CNT_W-1:0]   sync_count,
    output logic [CNT_W-1:0]   sync_err_count,
    output logic [CNT_W-1:0]   or_count
);

    state_e             state_q, state_d;
    logic [PHASE_W-1:0] k_q, k_d, k_new_s, k_use_s;
    logic               prev_q, prev_d;
    logic               pend_q, pend_d;
    logic [WORD_W-1:0]  hold_q, hold_d;
    logic [WORD_W-1:0]  out_data_q, out_data_d;
    logic               out_valid_q, out_valid_d;
    logic               out_sync_q, out_sync_d;
    logic               sync_any_s, edge_s;
    logic               inc_sync_s, inc_err_s;

    // Next-state: pend_q marks that the next completed word starts at the sync sample.
    always_comb begin
        sync_any_s  = |in_sync;
        edge_s      = sync_any_s & ~prev_q;
        k_new_s     = sync_phase(in_sync);
        state_d     = state_q;
        k_d         = k_q;
        k_use_s     = k_q;
        prev_d      = prev_q;
        pend_d      = pend_q;
        hold_d      = hold_q;
        out_data_d  = out_data_q;
        out_valid_d = 1'b0;
        out_sync_d  = 1'b0;
        inc_sync_s  = 1'b0;
        inc_err_s   = 1'b0;
        if (arm) begin
            state_d = SEARCH;
            pend_d  = 1'b0;
            if (in_valid) begin
                prev_d = sync_any_s;
                hold_d = in_data;
            end else begin
                prev_d = prev_q;
            end
        end else if (in_valid) begin
            prev_d = sync_any_s;
            hold_d = in_data;
            pend_d = 1'b0;
            case (state_q)
                SEARCH: begin
                    if (edge_s) begin
                        state_d    = LOCKED;
                        k_d        = k_new_s;
                        pend_d     = 1'b1;
                        inc_sync_s = 1'b1;
                    end else begin
                        state_d = SEARCH;
                    end
                end
                LOCKED: begin
                    out_valid_d = 1'b1;
                    out_sync_d  = pend_q;
                    if (edge_s && (k_new_s == k_q)) begin
                        inc_sync_s = 1'b1;
                        pend_d     = 1'b1;
                    end else if (edge_s) begin
                        inc_err_s = 1'b1;
                        // The word straddling a relock mixes two phases, so it is suppressed.
                        if (RELOCK) begin
                            k_d         = k_new_s;
                            k_use_s     = k_new_s;
                            pend_d      = 1'b1;
                            out_valid_d = 1'b0;
                            out_sync_d  = 1'b0;
                        end else begin
                            pend_d = 1'b0;
                        end
                    end else begin
                        pend_d = 1'b0;
                    end
                end
                default: state_d = SEARCH;
            endcase
            out_data_d = align_word(hold_q, in_data, k_use_s);
        end else begin
            pend_d = pend_q;
        end
    end

    // State and output registers.
    always_ff @(posedge ctrl_clk_in or negedge ctrl_reset_n) begin
        if (!ctrl_reset_n) begin
            state_q     <= SEARCH;
            k_q         <= '0;
            prev_q      <= 1'b0;
            pend_q      <= 1'b0;
            hold_q      <= '0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            out_sync_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            k_q         <= k_d;
            prev_q      <= prev_d;
            pend_q      <= pend_d;
            hold_q      <= hold_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
            out_sync_q  <= out_sync_d;
        end
    end

    assign out_data  = out_data_q;
    assign out_valid = out_valid_q;
    assign out_sync  = out_sync_q;
    assign locked    = (state_q == LOCKED);
    assign offset    = k_q;

    adc_5g_sat_counter #(.CNT_W(CNT_W)) u_sync_cnt (
        .clk   (ctrl_clk_in),
        .rst_n (ctrl_reset_n),
        .clr   (cnt_clr),
        .inc   (inc_sync_s),
        .count (sync_count)
    );

    adc_5g_sat_counter #(.CNT_W(CNT_W)) u_err_cnt (
        .clk   (ctrl_clk_in),
        .rst_n (ctrl_reset_n),
        .clr   (cnt_clr),
        .inc   (inc_err_s),
        .count (sync_err_count)
    );

`ifdef ADC5G_OVERRANGE_CNT_EN
    adc_5g_sat_counter #(.CNT_W(CNT_W)) u_or_cnt (
        .clk   (ctrl_clk_in),
        .rst_n (ctrl_reset_n),
        .clr   (cnt_clr),
        .inc   (in_valid & (|in_or)),
        .count (or_count)
    );
`else
    logic unused_or_s;
    assign unused_or_s = ^in_or;
    assign or_count    = '0;
`endif

endmodule

// File: tb/tb_adc_5g_sync_align.sv
// Directed bench for adc_5g_sync_align: a 32-bit-counter instance plus a 3-bit
// counter instance sharing the same stimulus to reach saturation quickly.
module tb_adc_5g_sync_align;

`ifdef ADC5G_OVERRANGE_CNT_EN
    localparam bit OR_EN = 1'b1;
`else
    localparam bit OR_EN = 1'b0;
`endif

    logic        clk;
    logic        rst_n;
    logic [63:0] in_data;
    logic [3:0]  in_sync;
    logic [1:0]  in_or;
    logic        in_valid;
    logic        arm;
    logic        cnt_clr;

    logic [63:0] out_data_a, out_data_b;
    logic        out_sync_a, out_sync_b;
    logic        out_valid_a, out_valid_b;
    logic        locked_a, locked_b;
    logic [1:0]  offset_a, offset_b;
    logic [31:0] sync_cnt_a, err_cnt_a, or_cnt_a;
    logic [2:0]  sync_cnt_b, err_cnt_b, or_cnt_b;

    int n_checks = 0;
    int n_errors = 0;

    adc_5g_sync_align #(.CNT_W(32), .RELOCK(1'b1)) u_dut (
        .ctrl_clk_in    (clk),
        .ctrl_reset_n   (rst_n),
        .in_data        (in_data),
        .in_sync        (in_sync),
        .in_or          (in_or),
        .in_valid       (in_valid),
        .arm            (arm),
        .cnt_clr        (cnt_clr),
        .out_data       (out_data_a),
        .out_sync       (out_sync_a),
        .out_valid      (out_valid_a),
        .locked         (locked_a),
        .offset         (offset_a),
        .sync_count     (sync_cnt_a),
        .sync_err_count (err_cnt_a),
        .or_count       (or_cnt_a)
    );

    adc_5g_sync_align #(.CNT_W(3), .RELOCK(1'b1)) u_sat (
        .ctrl_clk_in    (clk),
        .ctrl_reset_n   (rst_n),
        .in_data        (in_data),
        .in_sync        (in_sync),
        .in_or          (in_or),
        .in_valid       (in_valid),
        .arm            (arm),
        .cnt_clr        (cnt_clr),
        .out_data       (out_data_b),
        .out_sync       (out_sync_b),
        .out_valid      (out_valid_b),
        .locked         (locked_b),
        .offset         (offset_b),
        .sync_count     (sync_cnt_b),
        .sync_err_count (err_cnt_b),
        .or_count       (or_cnt_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [63:0] ramp(input logic [7:0] base);
        logic [63:0] w;
        for (int j = 0; j < 8; j++) w[8*j +: 8] = base + 8'(j);
        return w;
    endfunction

    task automatic step(input logic [63:0] d, input logic [3:0] s, input logic [1:0] o, input logic v);
        in_data  = d;
        in_sync  = s;
        in_or    = o;
        in_valid = v;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        rst_n = 1'b1; in_data = '0; in_sync = '0; in_or = '0; in_valid = 1'b0; arm = 1'b0; cnt_clr = 1'b0;
        #2 rst_n = 1'b0;
        @(posedge clk); @(posedge clk); #1;
        n_checks++; if (out_data_a !== 64'd0) begin n_errors++; $display("FAIL rst_data: got %h want 0", out_data_a); end
        n_checks++; if (out_valid_a !== 1'b0 || out_sync_a !== 1'b0) begin n_errors++; $display("FAIL rst_valid_sync: got %b%b want 00", out_valid_a, out_sync_a); end
        n_checks++; if (locked_a !== 1'b0 || offset_a !== 2'd0) begin n_errors++; $display("FAIL rst_lock: got %b/%0d want 0/0", locked_a, offset_a); end
        n_checks++; if (sync_cnt_a !== 32'd0 || err_cnt_a !== 32'd0 || or_cnt_a !== 32'd0) begin n_errors++; $display("FAIL rst_counts: got %0d/%0d/%0d want 0/0/0", sync_cnt_a, err_cnt_a, or_cnt_a); end
        @(negedge clk) rst_n = 1'b1;
        for (int i = 0; i < 3; i++) step(ramp(8'hE0 + 8'(i)), 4'b0000, 2'b00, 1'b1);
        n_checks++; if (out_valid_a !== 1'b0) begin n_errors++; $display("FAIL nosync_valid: got %b want 0", out_valid_a); end
        n_checks++; if (locked_a !== 1'b0) begin n_errors++; $display("FAIL nosync_locked: got %b want 0", locked_a); end
        n_checks++; if (sync_cnt_a !== 32'd0 || err_cnt_a !== 32'd0 || or_cnt_a !== 32'd0) begin n_errors++; $display("FAIL nosync_counts: got %0d/%0d/%0d want 0/0/0", sync_cnt_a, err_cnt_a, or_cnt_a); end
    endtask

    task automatic test_lock;
        step(ramp(8'd0), 4'b0100, 2'b10, 1'b1);
        n_checks++; if (locked_a !== 1'b1 || offset_a !== 2'd2) begin n_errors++; $display("FAIL lock_state: got %b/%0d want 1/2", locked_a, offset_a); end
        n_checks++; if (out_valid_a !== 1'b0) begin n_errors++; $display("FAIL lock_first_valid: got %b want 0", out_valid_a); end
        n_checks++; if (sync_cnt_a !== 32'd1) begin n_errors++; $display("FAIL lock_sync_count: got %0d want 1", sync_cnt_a); end
        n_checks++; if (or_cnt_a !== (OR_EN ? 32'd1 : 32'd0)) begin n_errors++; $display("FAIL lock_or_count: got %0d want %0d", or_cnt_a, OR_EN ? 1 : 0); end
        step(ramp(8'd16), 4'b0000, 2'b00, 1'b1);
        n_checks++; if (out_data_a !== 64'h13121110_07060504) begin n_errors++; $display("FAIL lock_data: got %h want 1312111007060504", out_data_a); end
        n_checks++; if (out_valid_a !== 1'b1 || out_sync_a !== 1'b1) begin n_errors++; $display("FAIL lock_flags: got v%b s%b want v1 s1", out_valid_a, out_sync_a); end
    endtask

    task automatic test_valid_toggle;
        step(ramp(8'd32), 4'b0000, 2'b00, 1'b1);
        n_checks++; if (out_data_a !== 64'h23222120_17161514 || out_valid_a !== 1'b1 || out_sync_a !== 1'b0) begin n_errors++; $display("FAIL tog_w0: got %h v%b s%b want 2322212017161514 v1 s0", out_data_a, out_valid_a, out_sync_a); end
        step(64'hDEADBEEF_CAFEF00D, 4'b0001, 2'b11, 1'b0);
        n_checks++; if (out_valid_a !== 1'b0) begin n_errors++; $display("FAIL tog_idle0_valid: got %b want 0", out_valid_a); end
        n_checks++; if (out_data_a !== 64'h23222120_17161514) begin n_errors++; $display("FAIL tog_idle0_hold: got %h want 2322212017161514", out_data_a); end
        step(ramp(8'd48), 4'b0000, 2'b00, 1'b1);
        n_checks++; if (out_data_a !== 64'h33323130_27262524 || out_valid_a !== 1'b1) begin n_errors++; $display("FAIL tog_w1: got %h v%b want 3332313027262524 v1", out_data_a, out_valid_a); end
        step(64'h01234567_89ABCDEF, 4'b0010, 2'b00, 1'b0);
        n_checks++; if (out_valid_a !== 1'b0) begin n_errors++; $display("FAIL tog_idle1_valid: got %b want 0", out_valid_a); end
        step(ramp(8'd64), 4'b0000, 2'b00, 1'b1);
        n_checks++; if (out_data_a !== 64'h43424140_37363534 || out_valid_a !== 1'b1) begin n_errors++; $display("FAIL tog_w2: got %h v%b want 4342414037363534 v1", out_data_a, out_valid_a); end
        n_checks++; if (err_cnt_a !== 32'd0 || offset_a !== 2'd2) begin n_errors++; $display("FAIL tog_idle_sync_ignored: got err %0d off %0d want 0/2", err_cnt_a, offset_a); end
    endtask

    task automatic test_relock;
        step(ramp(8'd80), 4'b0001, 2'b00, 1'b1);
        n_checks++; if (out_valid_a !== 1'b0) begin n_errors++; $display("FAIL relock_straddle_valid: got %b want 0", out_valid_a); end
        n_checks++; if (err_cnt_a !== 32'd1 || sync_cnt_a !== 32'd1) begin n_errors++; $display("FAIL relock_counts: got err %0d sync %0d want 1/1", err_cnt_a, sync_cnt_a); end
        n_checks++; if (offset_a !== 2'd0 || locked_a !== 1'b1) begin n_errors++; $display("FAIL relock_offset: got %0d/%b want 0/1", offset_a, locked_a); end
        step(ramp(8'd96), 4'b0000, 2'b00, 1'b1);
        n_checks++; if (out_data_a !== 64'h57565554_53525150) begin n_errors++; $display("FAIL relock_w0: got %h want 5756555453525150", out_data_a); end
        n_checks++; if (out_valid_a !== 1'b1 || out_sync_a !== 1'b1) begin n_errors++; $display("FAIL relock_flags: got v%b s%b want v1 s1", out_valid_a, out_sync_a); end
        step(ramp(8'd112), 4'b0000, 2'b00, 1'b1);
        n_checks++; if (out_data_a !== 64'h67666564_63626160 || out_sync_a !== 1'b0) begin n_errors++; $display("FAIL relock_w1: got %h s%b want 6766656463626160 s0", out_data_a, out_sync_a); end
    endtask

    task automatic test_arm;
        arm = 1'b1;
        step(ramp(8'h90), 4'b0100, 2'b00, 1'b1);
        arm = 1'b0;
        n_checks++; if (locked_a !== 1'b0 || out_valid_a !== 1'b0) begin n_errors++; $display("FAIL arm_state: got lock %b v%b want 0/0", locked_a, out_valid_a); end
        n_checks++; if (sync_cnt_a !== 32'd1 || err_cnt_a !== 32'd1 || offset_a !== 2'd0) begin n_errors++; $display("FAIL arm_edge_ignored: got %0d/%0d off %0d want 1/1 off 0", sync_cnt_a, err_cnt_a, offset_a); end
        step(ramp(8'h98), 4'b0000, 2'b00, 1'b1);
        n_checks++; if (out_valid_a !== 1'b0 || locked_a !== 1'b0) begin n_errors++; $display("FAIL arm_search: got v%b lock %b want 0/0", out_valid_a, locked_a); end
        step(ramp(8'hA0), 4'b0010, 2'b00, 1'b1);
        n_checks++; if (locked_a !== 1'b1 || offset_a !== 2'd1) begin n_errors++; $display("FAIL arm_relock: got %b/%0d want 1/1", locked_a, offset_a); end
        n_checks++; if (sync_cnt_a !== 32'd2) begin n_errors++; $display("FAIL arm_sync_count: got %0d want 2", sync_cnt_a); end
        step(ramp(8'hB0), 4'b0000, 2'b00, 1'b1);
        n_checks++; if (out_data_a !== 64'hB1B0A7A6_A5A4A3A2) begin n_errors++; $display("FAIL arm_data: got %h want B1B0A7A6A5A4A3A2", out_data_a); end
        n_checks++; if (out_valid_a !== 1'b1 || out_sync_a !== 1'b1) begin n_errors++; $display("FAIL arm_flags: got v%b s%b want v1 s1", out_valid_a, out_sync_a); end
    endtask

    task automatic test_counters;
        arm = 1'b1;
        step(ramp(8'd0), 4'b0000, 2'b00, 1'b1);
        arm = 1'b0;
        cnt_clr = 1'b1;
        step(ramp(8'd8), 4'b0001, 2'b01, 1'b1);
        cnt_clr = 1'b0;
        n_checks++; if (sync_cnt_a !== 32'd0 || err_cnt_a !== 32'd0 || or_cnt_a !== 32'd0) begin n_errors++; $display("FAIL clr_wins: got %0d/%0d/%0d want 0/0/0", sync_cnt_a, err_cnt_a, or_cnt_a); end
        n_checks++; if (locked_a !== 1'b1 || offset_a !== 2'd0) begin n_errors++; $display("FAIL clr_lock: got %b/%0d want 1/0", locked_a, offset_a); end
        for (int i = 0; i < 10; i++) begin
            step(ramp(8'(16 * i)), 4'b0000, 2'b01, 1'b1);
            step(ramp(8'(16 * i + 8)), 4'b0001, 2'b01, 1'b1);
        end
        n_checks++; if (sync_cnt_a !== 32'd10) begin n_errors++; $display("FAIL sat_sync_wide: got %0d want 10", sync_cnt_a); end
        n_checks++; if (sync_cnt_b !== 3'd7) begin n_errors++; $display("FAIL sat_sync_hold: got %0d want 7", sync_cnt_b); end
        n_checks++; if (or_cnt_a !== (OR_EN ? 32'd20 : 32'd0)) begin n_errors++; $display("FAIL or_count_wide: got %0d want %0d", or_cnt_a, OR_EN ? 20 : 0); end
        n_checks++; if (or_cnt_b !== (OR_EN ? 3'd7 : 3'd0)) begin n_errors++; $display("FAIL or_count_sat: got %0d want %0d", or_cnt_b, OR_EN ? 7 : 0); end
        for (int i = 0; i < 10; i++) begin
            step(ramp(8'(16 * i)), 4'b0000, 2'b00, 1'b1);
            step(ramp(8'(16 * i + 8)), (i % 2 == 0) ? 4'b0010 : 4'b0001, 2'b00, 1'b1);
        end
        n_checks++; if (err_cnt_a !== 32'd10 || sync_cnt_a !== 32'd10) begin n_errors++; $display("FAIL sat_err_wide: got err %0d sync %0d want 10/10", err_cnt_a, sync_cnt_a); end
        n_checks++; if (err_cnt_b !== 3'd7 || sync_cnt_b !== 3'd7) begin n_errors++; $display("FAIL sat_err_hold: got err %0d sync %0d want 7/7", err_cnt_b, sync_cnt_b); end
        cnt_clr = 1'b1;
        step(ramp(8'd0), 4'b0000, 2'b01, 1'b1);
        cnt_clr = 1'b0;
        n_checks++; if (sync_cnt_b !== 3'd0 || err_cnt_b !== 3'd0 || or_cnt_b !== 3'd0) begin n_errors++; $display("FAIL clr_from_sat: got %0d/%0d/%0d want 0/0/0", sync_cnt_b, err_cnt_b, or_cnt_b); end
        n_checks++; if (sync_cnt_a !== 32'd0 || err_cnt_a !== 32'd0 || or_cnt_a !== 32'd0) begin n_errors++; $display("FAIL clr_wide: got %0d/%0d/%0d want 0/0/0", sync_cnt_a, err_cnt_a, or_cnt_a); end
    endtask

    task automatic test_reset_midstream;
        step(ramp(8'd0), 4'b0000, 2'b00, 1'b1);
        step(ramp(8'd8), 4'b0001, 2'b00, 1'b1);
        #3 rst_n = 1'b0;
        #1;
        n_checks++; if (locked_a !== 1'b0 || sync_cnt_a !== 32'd0 || offset_a !== 2'd0) begin n_errors++; $display("FAIL mid_rst_async: got lock %b cnt %0d off %0d want 0/0/0", locked_a, sync_cnt_a, offset_a); end
        @(negedge clk) rst_n = 1'b1;
        step(ramp(8'h10), 4'b1000, 2'b00, 1'b1);
        n_checks++; if (locked_a !== 1'b1 || offset_a !== 2'd3 || sync_cnt_a !== 32'd1) begin n_errors++; $display("FAIL mid_first_edge: got lock %b off %0d cnt %0d want 1/3/1", locked_a, offset_a, sync_cnt_a); end
        step(ramp(8'h20), 4'b1000, 2'b00, 1'b1);
        n_checks++; if (out_data_a !== 64'h25242322_21201716 || out_sync_a !== 1'b1 || out_valid_a !== 1'b1) begin n_errors++; $display("FAIL mid_data: got %h v%b s%b want 2524232221201716 v1 s1", out_data_a, out_valid_a, out_sync_a); end
        n_checks++; if (sync_cnt_a !== 32'd1) begin n_errors++; $display("FAIL mid_level_not_edge: got %0d want 1", sync_cnt_a); end
    endtask

    initial begin
        test_reset();
        test_lock();
        test_valid_toggle();
        test_relock();
        test_arm();
        test_counters();
        test_reset_midstream();
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
